transfer_control_unit: RTL and testbench
========================================

// Module: transfer_control_unit
// PURPOSE
//   Sequencer that drives the load (R_in) and bus-drive (R_out) strobes of the
//   register units sharing one tri-state bus, plus one temp register (T).
//   Executes a MOVE (Rsrc -> Rdst) or SWAP (Rsrc <-> Rdst via T) per request.
//   Sits upstream of the register file: its strobes are the registers' R_in/R_out.
// PARAMETERS
//   NUM_REGS  4  number of bus registers controlled (2..2**SEL_W)
//   SEL_W     2  width of src/dst register selects
// PORTS
//   clk      in   1         system clock, rising edge
//   reset    in   1         asynchronous, active-high; forces IDLE, all strobes 0
//   start    in   1         request; sampled on rising clk edge only in IDLE
//   op       in   1         0 = MOVE, 1 = SWAP; sampled with start
//   src      in   SEL_W     source register index; sampled with start
//   dst      in   SEL_W     destination register index; sampled with start
//   R_in     out  NUM_REGS  one-hot load strobe per register
//   R_out    out  NUM_REGS  one-hot bus-drive strobe per register
//   T_in     out  1         load strobe of temp register
//   T_out    out  1         bus-drive strobe of temp register
//   busy     out  1         high in every state except IDLE
//   done     out  1         one-cycle pulse when the operation completes
//   err      out  1         valid with done; 1 = index out of range, no transfer
// BEHAVIOUR
//   - Reset values: R_in=0, R_out=0, T_in=0, T_out=0, busy=0, done=0, err=0.
//   - Moore FSM; all outputs decoded from registered state/latched operands only
//     (no combinational path from start/op/src/dst to any output).
//   - States: IDLE, MV, SW1, SW2, SW3, DONE.
//   - IDLE & start=1 at edge: latch op/src/dst, then:
//       src>=NUM_REGS or dst>=NUM_REGS -> DONE with err=1;
//       src==dst -> DONE with err=0 (no strobes, null operation);
//       else op=0 -> MV, op=1 -> SW1.
//   - MV : R_out[src]=1, R_in[dst]=1                  -> DONE
//   - SW1: R_out[src]=1, T_in=1                       -> SW2
//   - SW2: R_out[dst]=1, R_in[src]=1                  -> SW3
//   - SW3: T_out=1,      R_in[dst]=1                  -> DONE
//   - DONE: done=1, err as latched, busy=1            -> IDLE
//   - Latency from start edge: MOVE done in 2nd cycle after edge; SWAP in 4th;
//     null/error in 1st. Next start accepted in IDLE (cycle after DONE).
//   - start while busy is ignored (not queued); operands held stable internally.
//   - Bus rule: at most one of {R_out[*], T_out} high in any cycle; at most one
//     R_in bit high; R_in[i] and R_out[i] never both high for the same i.
//   - Register load occurs on the edge ending the strobed cycle (1-cycle strobe).
//   - Reset asserted mid-operation: strobes drop immediately (async), FSM to
//     IDLE, no done pulse; partially completed SWAP is not rolled back.
// TESTING
//   - Reset: assert reset mid-SW2 -> all outputs 0 same cycle, IDLE after release.
//   - MOVE src=1 dst=3, R1=1 R3=0 -> cycle1 R_out=0010 R_in=1000; cycle2 done=1;
//     R3=1, err=0.
//   - SWAP src=0 dst=2, R0=1 R2=0 -> SW1 R_out=0001 T_in; SW2 R_out=0100 R_in=0001;
//     SW3 T_out R_in=0100; done in cycle 4; R0=0 R2=1.
//   - src==dst=2, op=1 -> done=1 cycle 1, err=0, no strobe ever asserted.
//   - NUM_REGS=3, dst=3 -> done=1 err=1 cycle 1, no strobes; start held high
//     during a SWAP -> ignored, exactly one done per accepted start.
//   - Random 1000 ops vs reference register model; assert bus rule every cycle.

Source files
------------

// File: rtl/transfer_control_unit.sv
`timescale 1ns/1ps
// Bus transfer sequencer: issues one-hot register load/drive strobes (plus a temp
// register) to perform a MOVE or a SWAP between registers sharing one bus.
module transfer_control_unit #(
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_op,
  input  logic [SEL_W-1:0]    i_src,
  input  logic [SEL_W-1:0]    i_dst,
  output logic [NUM_REGS-1:0] o_r_in,
  output logic [NUM_REGS-1:0] o_r_out,
  output logic                o_t_in,
  output logic                o_t_out,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MV,
    S_SW1,
    S_SW2,
    S_SW3,
    S_DONE
  } state_t;

  localparam logic [SEL_W:0] LP_NUM = NUM_REGS[SEL_W:0];

  state_t             r_state;
  state_t             w_state_next;
  logic [SEL_W-1:0]   r_src;
  logic [SEL_W-1:0]   r_dst;
  logic               r_err;
  logic               w_range_err;
  logic [NUM_REGS-1:0] w_src_hot;
  logic [NUM_REGS-1:0] w_dst_hot;

  assign w_range_err = ({1'b0, i_src} >= LP_NUM) || ({1'b0, i_dst} >= LP_NUM);

  // Operands are captured only on an accepted start, so requests while busy
  // cannot disturb an operation in flight.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && i_start) begin
        r_src <= i_src;
        r_dst <= i_dst;
        r_err <= w_range_err;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (w_range_err || (i_src == i_dst)) w_state_next = S_DONE;
          else if (i_op)                        w_state_next = S_SW1;
          else                                  w_state_next = S_MV;
        end
      end
      S_MV:    w_state_next = S_DONE;
      S_SW1:   w_state_next = S_SW2;
      S_SW2:   w_state_next = S_SW3;
      S_SW3:   w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_hot
      assign w_src_hot[gi] = (r_src == SEL_W'(gi));
      assign w_dst_hot[gi] = (r_dst == SEL_W'(gi));
    end
  endgenerate

  // Strobe states are only entered with src != dst, so the bus rule holds by construction.
  always_comb begin
    o_r_in  = '0;
    o_r_out = '0;
    o_t_in  = 1'b0;
    o_t_out = 1'b0;
    o_done  = 1'b0;
    o_err   = 1'b0;
    o_busy  = (r_state != S_IDLE);
    case (r_state)
      S_MV: begin
        o_r_out = w_src_hot;
        o_r_in  = w_dst_hot;
      end
      S_SW1: begin
        o_r_out = w_src_hot;
        o_t_in  = 1'b1;
      end
      S_SW2: begin
        o_r_out = w_dst_hot;
        o_r_in  = w_src_hot;
      end
      S_SW3: begin
        o_t_out = 1'b1;
        o_r_in  = w_dst_hot;
      end
      S_DONE: begin
        o_done = 1'b1;
        o_err  = r_err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_transfer_control_unit.sv
`timescale 1ns/1ps
// Directed and random checks of transfer_control_unit driving a small register-file model.
module tb_transfer_control_unit;

  logic       clk;
  logic       reset;
  logic       start, op;
  logic [1:0] src, dst;
  logic [3:0] r_in, r_out;
  logic       t_in, t_out, busy, done, err;

  logic       start3, op3;
  logic [1:0] src3, dst3;
  logic [2:0] r_in3, r_out3;
  logic       t_in3, t_out3, busy3, done3, err3;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  logic [7:0] rf [4];
  logic [7:0] t_reg;
  logic [7:0] bus;
  logic [7:0] preset_val [4];
  logic       preset_en;
  logic [7:0] mdl [4];

  transfer_control_unit #(.NUM_REGS(4), .SEL_W(2)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_op(op), .i_src(src), .i_dst(dst),
    .o_r_in(r_in), .o_r_out(r_out), .o_t_in(t_in), .o_t_out(t_out),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  transfer_control_unit #(.NUM_REGS(3), .SEL_W(2)) dut3 (
    .i_clk(clk), .i_reset(reset), .i_start(start3), .i_op(op3), .i_src(src3), .i_dst(dst3),
    .o_r_in(r_in3), .o_r_out(r_out3), .o_t_in(t_in3), .o_t_out(t_out3),
    .o_busy(busy3), .o_done(done3), .o_err(err3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registers on the shared bus, loaded by the DUT strobes
  always_comb begin
    bus = 8'h00;
    for (int i = 0; i < 4; i++) if (r_out[i]) bus = rf[i];
    if (t_out) bus = t_reg;
  end

  always @(posedge clk) begin
    if (preset_en) begin
      for (int i = 0; i < 4; i++) rf[i] <= preset_val[i];
      t_reg <= 8'h00;
    end else begin
      for (int i = 0; i < 4; i++) if (r_in[i]) rf[i] <= bus;
      if (t_in) t_reg <= bus;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      n_cmp++;
      if (($countones(r_out) + int'(t_out)) > 1 || $countones(r_in) > 1 || (r_in & r_out) != 4'b0) begin
        n_bad++;
        $display("FAIL bus_rule t=%0t r_in=%b r_out=%b t_out=%b", $time, r_in, r_out, t_out);
      end
      n_cmp++;
      if (($countones(r_out3) + int'(t_out3)) > 1 || $countones(r_in3) > 1 || (r_in3 & r_out3) != 3'b0) begin
        n_bad++;
        $display("FAIL bus_rule3 t=%0t r_in=%b r_out=%b t_out=%b", $time, r_in3, r_out3, t_out3);
      end
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preset(input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2, input logic [7:0] v3);
    preset_val[0] = v0; preset_val[1] = v1; preset_val[2] = v2; preset_val[3] = v3;
    mdl[0] = v0; mdl[1] = v1; mdl[2] = v2; mdl[3] = v3;
    preset_en = 1'b1;
    tick();
    preset_en = 1'b0;
  endtask

  // Issues one request from IDLE; returns cycles to done (-1 on timeout) and ends back in IDLE.
  task automatic run_op(input logic o, input logic [1:0] s, input logic [1:0] d, output int lat);
    start = 1'b1; op = o; src = s; dst = d;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({r_in, r_out, t_in, t_out, busy, done, err} !== 13'b0) begin
      n_bad++; $display("FAIL reset_state got=%b exp=0", {r_in, r_out, t_in, t_out, busy, done, err});
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle busy=%b exp=0", busy); end
    preset(8'h01, 8'h00, 8'h00, 8'h00);
    start = 1'b1; op = 1'b1; src = 2'd0; dst = 2'd2;
    tick();
    start = 1'b0;
    tick();
    n_cmp++;
    if (r_out !== 4'b0100 || r_in !== 4'b0001) begin
      n_bad++; $display("FAIL reset_pre_sw2 r_out=%b r_in=%b exp 0100/0001", r_out, r_in);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({r_in, r_out, t_in, t_out, busy, done, err} !== 13'b0) begin
      n_bad++; $display("FAIL reset_async got=%b exp=0", {r_in, r_out, t_in, t_out, busy, done, err});
    end
    tick();
    reset = 1'b0;
    begin
      int snap;
      snap = done_cnt;
      tick(); tick(); tick();
      n_cmp++;
      if (busy !== 1'b0 || done_cnt != snap) begin
        n_bad++; $display("FAIL reset_release busy=%b dones=%0d exp busy=0 dones=0", busy, done_cnt - snap);
      end
    end
  endtask

  task automatic test_move();
    preset(8'h00, 8'h01, 8'h00, 8'h00);
    start = 1'b1; op = 1'b0; src = 2'd1; dst = 2'd3;
    tick();
    start = 1'b0;
    n_cmp++;
    if (r_out !== 4'b0010 || r_in !== 4'b1000 || t_in !== 1'b0 || t_out !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      n_bad++; $display("FAIL move_c1 r_out=%b r_in=%b t=%b%b busy=%b done=%b exp 0010/1000/00/1/0", r_out, r_in, t_in, t_out, busy, done);
    end
    tick();
    n_cmp++;
    if (done !== 1'b1 || err !== 1'b0 || r_in !== 4'b0 || r_out !== 4'b0 || rf[3] !== 8'h01 || rf[1] !== 8'h01) begin
      n_bad++; $display("FAIL move_c2 done=%b err=%b R1=%h R3=%h exp done=1 err=0 R1=01 R3=01", done, err, rf[1], rf[3]);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL move_idle busy=%b done=%b exp 0/0", busy, done); end
  endtask

  task automatic test_swap();
    preset(8'h01, 8'h55, 8'h00, 8'hAA);
    start = 1'b1; op = 1'b1; src = 2'd0; dst = 2'd2;
    tick();
    start = 1'b0;
    n_cmp++;
    if (r_out !== 4'b0001 || t_in !== 1'b1 || r_in !== 4'b0 || t_out !== 1'b0) begin
      n_bad++; $display("FAIL swap_sw1 r_out=%b t_in=%b r_in=%b t_out=%b exp 0001/1/0000/0", r_out, t_in, r_in, t_out);
    end
    tick();
    n_cmp++;
    if (r_out !== 4'b0100 || r_in !== 4'b0001 || t_in !== 1'b0 || t_out !== 1'b0) begin
      n_bad++; $display("FAIL swap_sw2 r_out=%b r_in=%b exp 0100/0001", r_out, r_in);
    end
    tick();
    n_cmp++;
    if (t_out !== 1'b1 || r_in !== 4'b0100 || r_out !== 4'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL swap_sw3 t_out=%b r_in=%b r_out=%b done=%b exp 1/0100/0000/0", t_out, r_in, r_out, done);
    end
    tick();
    n_cmp++;
    if (done !== 1'b1 || err !== 1'b0 || rf[0] !== 8'h00 || rf[2] !== 8'h01 || rf[1] !== 8'h55 || rf[3] !== 8'hAA) begin
      n_bad++; $display("FAIL swap_done done=%b err=%b R0=%h R2=%h exp 1/0/00/01", done, err, rf[0], rf[2]);
    end
    tick();
  endtask

  task automatic test_null();
    start = 1'b1; op = 1'b1; src = 2'd2; dst = 2'd2;
    tick();
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || err !== 1'b0 || {r_in, r_out, t_in, t_out} !== 10'b0) begin
      n_bad++; $display("FAIL null_op done=%b err=%b strobes=%b exp 1/0/0", done, err, {r_in, r_out, t_in, t_out});
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || {r_in, r_out, t_in, t_out} !== 10'b0) begin
      n_bad++; $display("FAIL null_idle busy=%b strobes=%b exp 0/0", busy, {r_in, r_out, t_in, t_out});
    end
  endtask

  task automatic test_range_err();
    start3 = 1'b1; op3 = 1'b1; src3 = 2'd0; dst3 = 2'd3;
    tick();
    start3 = 1'b0;
    n_cmp++;
    if (done3 !== 1'b1 || err3 !== 1'b1 || {r_in3, r_out3, t_in3, t_out3} !== 8'b0) begin
      n_bad++; $display("FAIL err_dst done=%b err=%b strobes=%b exp 1/1/0", done3, err3, {r_in3, r_out3, t_in3, t_out3});
    end
    tick();
    n_cmp++;
    if (busy3 !== 1'b0 || done3 !== 1'b0 || err3 !== 1'b0) begin
      n_bad++; $display("FAIL err_idle busy=%b done=%b err=%b exp 0/0/0", busy3, done3, err3);
    end
    start3 = 1'b1; op3 = 1'b0; src3 = 2'd3; dst3 = 2'd1;
    tick();
    start3 = 1'b0;
    n_cmp++;
    if (done3 !== 1'b1 || err3 !== 1'b1 || {r_in3, r_out3} !== 6'b0) begin
      n_bad++; $display("FAIL err_src done=%b err=%b exp 1/1", done3, err3);
    end
    tick();
    start3 = 1'b1; op3 = 1'b0; src3 = 2'd2; dst3 = 2'd0;
    tick();
    start3 = 1'b0;
    n_cmp++;
    if (r_out3 !== 3'b100 || r_in3 !== 3'b001 || done3 !== 1'b0) begin
      n_bad++; $display("FAIL move3_c1 r_out=%b r_in=%b done=%b exp 100/001/0", r_out3, r_in3, done3);
    end
    tick();
    n_cmp++;
    if (done3 !== 1'b1 || err3 !== 1'b0) begin n_bad++; $display("FAIL move3_done done=%b err=%b exp 1/0", done3, err3); end
    tick();
  endtask

  task automatic test_start_held();
    int snap;
    preset(8'h11, 8'h22, 8'h33, 8'h44);
    snap = done_cnt;
    start = 1'b1; op = 1'b1; src = 2'd1; dst = 2'd3;
    tick();
    src = 2'd0; dst = 2'd2;
    n_cmp++;
    if (r_out !== 4'b0010 || t_in !== 1'b1) begin n_bad++; $display("FAIL held_sw1 r_out=%b t_in=%b exp 0010/1", r_out, t_in); end
    tick();
    n_cmp++;
    if (r_out !== 4'b1000 || r_in !== 4'b0010) begin n_bad++; $display("FAIL held_sw2 r_out=%b r_in=%b exp 1000/0010", r_out, r_in); end
    tick();
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    n_cmp++;
    if (done_cnt - snap != 1 || rf[1] !== 8'h44 || rf[3] !== 8'h22 || rf[0] !== 8'h11 || rf[2] !== 8'h33) begin
      n_bad++; $display("FAIL held_once dones=%0d R0..3=%h %h %h %h exp 1 11 44 33 22", done_cnt - snap, rf[0], rf[1], rf[2], rf[3]);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    preset(8'd10, 8'd20, 8'd30, 8'd40);
    run_op(1'b0, 2'd0, 2'd1, lat);
    n_cmp++;
    if (lat != 2) begin n_bad++; $display("FAIL b2b_move_lat got=%0d exp=2", lat); end
    run_op(1'b1, 2'd2, 2'd3, lat);
    n_cmp++;
    if (lat != 4) begin n_bad++; $display("FAIL b2b_swap_lat got=%0d exp=4", lat); end
    run_op(1'b0, 2'd3, 2'd0, lat);
    n_cmp++;
    if (rf[0] !== 8'd30 || rf[1] !== 8'd10 || rf[2] !== 8'd40 || rf[3] !== 8'd30) begin
      n_bad++; $display("FAIL b2b_regs got=%0d %0d %0d %0d exp=30 10 40 30", rf[0], rf[1], rf[2], rf[3]);
    end
  endtask

  task automatic test_random();
    int lat, exp_lat;
    logic o;
    logic [1:0] s, d;
    logic [7:0] tmp;
    preset(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    for (int n = 0; n < 1000; n++) begin
      o = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      d = 2'($urandom_range(0, 3));
      run_op(o, s, d, lat);
      if (s == d) exp_lat = 1;
      else if (o) exp_lat = 4;
      else exp_lat = 2;
      if (s != d) begin
        tmp = mdl[s];
        if (o) mdl[s] = mdl[d];
        mdl[d] = tmp;
      end
      n_cmp++;
      if (lat != exp_lat) begin n_bad++; $display("FAIL rand_lat op=%0d s=%0d d=%0d got=%0d exp=%0d", o, s, d, lat, exp_lat); end
      n_cmp++;
      if (rf[0] !== mdl[0] || rf[1] !== mdl[1] || rf[2] !== mdl[2] || rf[3] !== mdl[3]) begin
        n_bad++; $display("FAIL rand_regs op=%0d s=%0d d=%0d got=%h %h %h %h exp=%h %h %h %h",
                          o, s, d, rf[0], rf[1], rf[2], rf[3], mdl[0], mdl[1], mdl[2], mdl[3]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; op = 1'b0; src = 2'd0; dst = 2'd0;
    start3 = 1'b0; op3 = 1'b0; src3 = 2'd0; dst3 = 2'd0;
    preset_en = 1'b0;
    for (int i = 0; i < 4; i++) preset_val[i] = 8'h00;
    tick(); tick();
    test_reset();
    test_move();
    test_swap();
    test_null();
    test_range_err();
    test_start_held();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
